image_frame_rx: RTL

Receiving end of the 16×16 binary-image byte stream that the board-level pattern streamer feeds into the MNIST logic-gate network.

- Accepts one pattern byte per valid cycle and tracks the byte position within the frame.
- Assembles 2·ROWS bytes into a full image register and hands it to the classifier core through a valid/ready handshake.
- Flags overruns when the consumer is too slow, and flags misalignment when an explicit sync marker arrives mid-frame.

---
 rtl/image_frame_rx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/image_frame_rx.sv
// Byte-stream receiver for the 16-pixel-wide binary image feed: assembles 2*ROWS bytes
// into a frame and offers it on a valid/ready port. Define IMAGE_FRAME_RX_POPCOUNT_EN for frame_ones.
`ifdef IMAGE_FRAME_RX_POPCOUNT_EN
module image_frame_rx_popcnt8 (
  input  logic [7:0] byte_in,
  output logic [3:0] ones
);
  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'b000, byte_in[i]};
  end
endmodule
`endif

module image_frame_rx #(
  parameter  int ROWS = 16,
  localparam int FW   = 16 * ROWS,
  localparam int NB   = 2 * ROWS,
  localparam int BIW  = $clog2(NB),
  localparam int OW   = $clog2(FW + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_byte,
  input  logic           in_valid,
  input  logic           in_sync,
  output logic [FW-1:0]  frame,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic [BIW-1:0] byte_index,
  output logic           overrun,
  output logic           sync_err,
  output logic [OW-1:0]  frame_ones
);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(NB - 1);

  logic [NB-1:0][7:0] asm_q, asm_d;
  logic [BIW-1:0]     byte_index_q, byte_index_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic               frame_valid_q, frame_valid_d;
  logic               overrun_q, overrun_d;
  logic               sync_err_q, sync_err_d;
  logic               realign, complete, pop, slot_free, load;
  logic [FW-1:0]      img;

  // A sync marker at byte 0 is an ordinary accept; only a mid-frame marker realigns.
  always_comb begin
    realign   = in_valid && in_sync && (byte_index_q != '0);
    complete  = in_valid && !realign && (byte_index_q == LAST_IDX);
    pop       = frame_valid_q && frame_ready;
    slot_free = !frame_valid_q || frame_ready;
    load      = complete && slot_free;
  end

  always_comb begin
    asm_d        = asm_q;
    byte_index_d = byte_index_q;
    if (realign) begin
      asm_d[0]     = in_byte;
      byte_index_d = BIW'(1);
    end else if (in_valid) begin
      asm_d[byte_index_q] = in_byte;
      byte_index_d        = complete ? '0 : byte_index_q + BIW'(1);
    end
  end

  // Row r = {byte 2r, byte 2r+1}: even bytes land in the upper half of each row.
  always_comb begin
    img = '0;
    for (int r = 0; r < ROWS; r++) begin
      img[16*r+8 +: 8] = asm_d[2*r];
      img[16*r   +: 8] = asm_d[2*r+1];
    end
  end

  always_comb begin
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    if (load) begin
      frame_d       = img;
      frame_valid_d = 1'b1;
    end else if (pop) begin
      frame_valid_d = 1'b0;
    end
    overrun_d  = overrun_q | (complete & ~slot_free);
    sync_err_d = sync_err_q | realign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q         <= '0;
      byte_index_q  <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      asm_q         <= asm_d;
      byte_index_q  <= byte_index_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign byte_index  = byte_index_q;
  assign overrun     = overrun_q;
  assign sync_err    = sync_err_q;

`ifdef IMAGE_FRAME_RX_POPCOUNT_EN
  logic [3:0]    byte_ones;
  logic [OW-1:0] acc_q, acc_d, ones_q, ones_d, acc_sum;

  image_frame_rx_popcnt8 u_popcnt (.byte_in(in_byte), .ones(byte_ones));

  // The accumulator runs alongside the assembly buffer so frame_ones loads with frame.
  always_comb begin
    acc_sum = acc_q + OW'(byte_ones);
    acc_d   = acc_q;
    ones_d  = ones_q;
    if (realign)       acc_d = OW'(byte_ones);
    else if (complete) acc_d = '0;
    else if (in_valid) acc_d = acc_sum;
    if (load) ones_d = acc_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      ones_q <= '0;
    end else begin
      acc_q  <= acc_d;
      ones_q <= ones_d;
    end
  end

  assign frame_ones = ones_q;
`else
  assign frame_ones = '0;
`endif
endmodule
